// File: rtl/sda_gmem_rd_arbiter.sv
// Two-requester read-burst arbiter onto a single gmem AXI read channel, one burst in flight.
// Define SDA_GMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is fixed priority (s0 wins ties).
module sda_gmem_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [7:0]            s0_arlen,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [7:0]            s1_arlen,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  m_axi_gmem_ARVALID,
  input  logic                  m_axi_gmem_ARREADY,
  output logic [ADDR_WIDTH-1:0] m_axi_gmem_ARADDR,
  output logic [7:0]            m_axi_gmem_ARLEN,
  input  logic                  m_axi_gmem_RVALID,
  output logic                  m_axi_gmem_RREADY,
  input  logic [DATA_WIDTH-1:0] m_axi_gmem_RDATA,
  input  logic [1:0]            m_axi_gmem_RRESP,
  input  logic                  m_axi_gmem_RLAST,
  output logic                  owner,
  output logic                  protocol_err
);

  localparam int unsigned LEN_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [LEN_W-1:0]      arlen_q, arlen_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic                  perr_q, perr_d;
  logic                  any_req;
  logic                  winner;
  logic                  rready_c;

  assign any_req = s0_arvalid | s1_arvalid;

`ifdef SDA_GMEM_ARB_ROUND_ROBIN_EN
  // rr_ptr_q names the requester favoured on the next tie
  logic rr_ptr_q, rr_ptr_d;

  assign winner   = (s0_arvalid & s1_arvalid) ? rr_ptr_q : s1_arvalid;
  assign rr_ptr_d = (state_q == IDLE && any_req) ? ~winner : rr_ptr_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign winner = s1_arvalid & ~s0_arvalid;
`endif

  // R payload is a pure pass-through to both requesters
  assign s_rdata = m_axi_gmem_RDATA;
  assign s_rresp = m_axi_gmem_RRESP;
  assign s_rlast = m_axi_gmem_RLAST;

  assign m_axi_gmem_ARADDR = araddr_q;
  assign m_axi_gmem_ARLEN  = arlen_q;
  assign owner             = owner_q;
  assign protocol_err      = perr_q;
  assign rready_c          = owner_q ? s1_rready : s0_rready;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      araddr_q <= '0;
      arlen_q  <= '0;
      beat_q   <= '0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      beat_q   <= beat_d;
      perr_q   <= perr_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    araddr_d           = araddr_q;
    arlen_d            = arlen_q;
    beat_d             = beat_q;
    perr_d             = perr_q;
    s0_arready         = 1'b0;
    s1_arready         = 1'b0;
    s0_rvalid          = 1'b0;
    s1_rvalid          = 1'b0;
    m_axi_gmem_ARVALID = 1'b0;
    m_axi_gmem_RREADY  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // gate with reset so no grant is signalled while reset is held
        if (any_req && ap_rst_n) begin
          s0_arready = ~winner;
          s1_arready = winner;
          owner_d    = winner;
          araddr_d   = winner ? s1_araddr : s0_araddr;
          arlen_d    = winner ? s1_arlen : s0_arlen;
          beat_d     = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        m_axi_gmem_ARVALID = 1'b1;
        if (m_axi_gmem_ARREADY) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_axi_gmem_RREADY = rready_c;
        s0_rvalid         = ~owner_q & m_axi_gmem_RVALID;
        s1_rvalid         = owner_q & m_axi_gmem_RVALID;
        if (m_axi_gmem_RVALID && rready_c) begin
          if (beat_q != '1) begin
            beat_d = beat_q + LEN_W'(1);
          end
          // beat_q counts beats already taken, so the last beat must see beat_q == arlen
          if (m_axi_gmem_RLAST) begin
            if (beat_q != arlen_q) begin
              perr_d = 1'b1;
            end
            state_d = IDLE;
          end else if (beat_q == arlen_q) begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
